// File: rtl/step_phase_decoder.sv
// rtl/step_phase_decoder.sv - stepper coil phase decoder: sync, glitch filter, half-step tracking FSM
// Optional stall detector enabled by defining STEP_DEC_STALL_EN.
module step_phase_decoder #(
   parameter int POS_W        = 16,
   parameter int FILT_CYCLES  = 4,
   parameter int STALL_CYCLES = 1000
) (
   input  logic                    clk0,
   input  logic                    rst,
   input  logic [3:0]              phase,
   input  logic                    pos_clr,
   input  logic                    err_clr,
   output logic                    step_pulse,
   output logic                    dir,
   output logic signed [POS_W-1:0] position,
   output logic                    locked,
   output logic                    err_skip,
   output logic                    err_invalid,
   output logic                    stall
);

   typedef enum logic {ACQUIRE, TRACK} state_t;

   localparam logic [7:0] FILT = 8'(FILT_CYCLES);

   logic [3:0]       sync1, sync2;
   logic [1:0]       sync_vld;
   logic [3:0]       last;
   logic             last_vld;
   logic [7:0]       cnt, cnt_n;
   logic             same, accept;

   state_t           state, state_n;
   logic [2:0]       idx, idx_n;
   logic [POS_W-1:0] pos_n;
   logic             dir_n, pulse_n, skip_n, inv_n;
   logic [3:0]       dec;
   logic [2:0]       delta;

   // Half-step table lookup: {valid, index}
   function automatic logic [3:0] decode(input logic [3:0] p);
      case (p)
         4'b1001: return 4'b1_000;
         4'b0001: return 4'b1_001;
         4'b0011: return 4'b1_010;
         4'b0010: return 4'b1_011;
         4'b0110: return 4'b1_100;
         4'b0100: return 4'b1_101;
         4'b1100: return 4'b1_110;
         4'b1000: return 4'b1_111;
         default: return 4'b0_000;
      endcase
   endfunction

   // Two-flop synchronizer; sync_vld marks when sync2 holds a real post-reset sample
   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         sync1    <= 4'b0;
         sync2    <= 4'b0;
         sync_vld <= 2'b0;
      end else begin
         sync1    <= phase;
         sync2    <= sync1;
         sync_vld <= {sync_vld[0], 1'b1};
      end
   end

   // Stability counter: counts consecutive equal samples, saturating at FILT
   always_comb begin
      same  = last_vld && (sync2 == last);
      cnt_n = cnt;
      if (sync_vld[1]) begin
         if (!same)
            cnt_n = 8'd1;
         else if (cnt != FILT)
            cnt_n = cnt + 8'd1;
      end
      // Fire exactly once, on the sample that brings the count to FILT
      accept = sync_vld[1] && (cnt_n == FILT) && !(same && (cnt == FILT));
   end

   // Filter state register
   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         last     <= 4'b0;
         last_vld <= 1'b0;
         cnt      <= 8'd0;
      end else if (sync_vld[1]) begin
         last     <= sync2;
         last_vld <= 1'b1;
         cnt      <= cnt_n;
      end
   end

   // Next-state, step and error logic for accepted patterns
   always_comb begin
      state_n = state;
      idx_n   = idx;
      pos_n   = position;
      dir_n   = dir;
      pulse_n = 1'b0;
      skip_n  = err_skip & ~err_clr;
      inv_n   = err_invalid & ~err_clr;
      dec     = decode(sync2);
      delta   = dec[2:0] - idx;
      if (accept) begin
         if (!dec[3]) begin
            inv_n   = 1'b1;
            state_n = ACQUIRE;
         end else if (state == ACQUIRE) begin
            idx_n   = dec[2:0];
            state_n = TRACK;
         end else begin
            idx_n = dec[2:0];
            case (delta)
               3'd0: ;
               3'd1: begin
                  pulse_n = 1'b1;
                  dir_n   = 1'b1;
                  pos_n   = position + POS_W'(1);
               end
               3'd7: begin
                  pulse_n = 1'b1;
                  dir_n   = 1'b0;
                  pos_n   = position - POS_W'(1);
               end
               default: skip_n = 1'b1;
            endcase
         end
      end
      if (pos_clr)
         pos_n = '0;
   end

   // State and output registers
   always_ff @(posedge clk0 or posedge rst) begin
      if (rst) begin
         state       <= ACQUIRE;
         idx         <= 3'd0;
         position    <= '0;
         dir         <= 1'b1;
         step_pulse  <= 1'b0;
         err_skip    <= 1'b0;
         err_invalid <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         position    <= pos_n;
         dir         <= dir_n;
         step_pulse  <= pulse_n;
         err_skip    <= skip_n;
         err_invalid <= inv_n;
      end
   end

   assign locked = (state == TRACK);

`ifdef STEP_DEC_STALL_EN
   localparam logic [19:0] STALL_LIM = 20'(STALL_CYCLES);
   logic [19:0] stall_cnt;

   // Idle counter while tracking; restarts on every step and whenever tracking ends
   always_ff @(posedge clk0 or posedge rst) begin
      if (rst)
         stall_cnt <= 20'd0;
      else if (state_n != TRACK || pulse_n)
         stall_cnt <= 20'd0;
      else if (stall_cnt != STALL_LIM)
         stall_cnt <= stall_cnt + 20'd1;
   end

   assign stall = (stall_cnt == STALL_LIM);
`else
   logic [19:0] unused_stall_cfg;
   assign unused_stall_cfg = 20'(STALL_CYCLES);
   assign stall = 1'b0;
`endif

endmodule

// File: doc/step_phase_decoder.md
STEP_PHASE_DECODER -- requirements
Module: step_phase_decoder

Interface
REQ-001 Parameter POS_W, default 16: width of signed position counter.
REQ-002 Parameter FILT_CYCLES, default 4 (legal 1..255): consecutive identical synchronized samples required to accept a phase pattern.
REQ-003 Parameter STALL_CYCLES, default 1000 (legal 2..2^20-1): idle cycles in TRACK before stall flag (only with STEP_DEC_STALL_EN).
REQ-004 clk0  in  1  sole clock, rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 phase  in  4  coil drive pattern from the sequencer, asynchronous to clk0.
REQ-007 pos_clr  in  1  synchronous clear of position, single-cycle strobe.
REQ-008 err_clr  in  1  synchronous clear of sticky error flags.
REQ-009 step_pulse  out  1  one-cycle strobe per accepted half-step.
REQ-010 dir  out  1  direction of last accepted step: 1 = forward (index +1), 0 = reverse.
REQ-011 position  out  POS_W  signed accumulated half-step count.
REQ-012 locked  out  1  high while FSM in TRACK.
REQ-013 err_skip  out  1  sticky: accepted pattern jumped by more than one half-step.
REQ-014 err_invalid  out  1  sticky: accepted pattern not in half-step table.
REQ-015 stall  out  1  no accepted step for STALL_CYCLES cycles while locked (tied 0 without macro).

Function
REQ-016 phase SHALL pass a 2-flop synchronizer; all further logic uses the synchronized value.
REQ-017 Half-step table, index 0..7: 1001, 0001, 0011, 0010, 0110, 0100, 1100, 1000; all other 8 codes invalid.
REQ-018 Filter: pattern accepted when synchronized value equals itself for FILT_CYCLES consecutive samples; any change restarts count; each stable pattern accepted once.
REQ-019 Latency: step_pulse SHALL assert exactly 2+FILT_CYCLES rising edges after the first edge sampling a new stable phase.
REQ-020 FSM states ACQUIRE, TRACK; reset state ACQUIRE.
REQ-021 ACQUIRE, accepted valid pattern: store index, go TRACK, no step_pulse, position unchanged.
REQ-022 ACQUIRE, accepted invalid pattern: set err_invalid, stay ACQUIRE.
REQ-023 TRACK, delta = +1 mod 8: step_pulse=1, dir=1, position+1; delta = -1 mod 8: step_pulse=1, dir=0, position-1; store index.
REQ-024 TRACK, delta of +-2, +-3 or 4: set err_skip, store new index (resync), no step_pulse, position and dir unchanged, stay TRACK.
REQ-025 TRACK, accepted invalid pattern: set err_invalid, go ACQUIRE, position held.
REQ-026 position wraps two's-complement (max +1 -> min, min -1 -> max), no saturation.
REQ-027 pos_clr with a step in same cycle: position becomes 0, step_pulse and dir still update.
REQ-028 err_clr coincident with a new error event: flag remains set (set wins).

Reset
REQ-029 On rst: FSM=ACQUIRE, synchronizer and filter cleared, step_pulse=0, dir=1, position=0, locked=0, err_skip=0, err_invalid=0, stall=0, stall counter=0.
REQ-030 rst mid-filter or mid-step SHALL discard the pending pattern; first post-reset stable pattern only acquires.

Configuration
REQ-031 Macro STEP_DEC_STALL_EN defined: counter increments each cycle in TRACK, clears on step_pulse, on leaving TRACK and on reset; stall=1 when count reaches STALL_CYCLES, clears on next step_pulse or leaving TRACK.
REQ-032 Macro STEP_DEC_STALL_EN undefined: no counter logic, stall tied 0, STALL_CYCLES ignored.

Verification
REQ-033 After reset, phase=1001 stable -> locked=1 after 2+FILT_CYCLES cycles, no step_pulse, position=0.
REQ-034 Locked at 1001, drive 1000,1100,0100 each held 10 cycles -> 3 step_pulses, dir=0, position=-3.
REQ-035 Locked at 0001, drive 0011 then 0110 -> one step_pulse (+1), then err_skip=1, position=1, locked=1.
REQ-036 Locked, drive 1111 -> err_invalid=1, locked=0; err_clr pulse -> err_invalid=0; single-cycle glitch 0000 (< FILT_CYCLES) -> no flag.
REQ-037 position=32767 (POS_W=16), forward step -> position=-32768; pos_clr same cycle as step -> position=0.
REQ-038 With STEP_DEC_STALL_EN, STALL_CYCLES=20: locked, no change 20 cycles -> stall=1; next valid step -> stall=0; without macro stall stays 0.
